control_estacionamiento: RTL and testbench

Occupancy controller for the parking counter. Takes one-cycle debounced pulses from the entry and exit sensor debouncers and arbitrates them onto a single shared occupancy counter, one grant at a time. Each accepted event drives the matching barrier open for a fixed time. Sits between the two debouncers and the display/barrier drivers, on the 12 MHz `clk` domain.

---
 rtl/control_estacionamiento.sv | 166 ++++++++++++++++
 tb/tb_control_estacionamiento.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/control_estacionamiento.sv
// control_estacionamiento: parking occupancy controller.
// Arbitrates one-cycle entry/exit pulses onto a single occupancy counter,
// one grant at a time, and holds the matching barrier open for GATE_TICKS
// cycles per accepted event.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous, active-high reset
//   pulso_entrada    one-cycle car-at-entry pulse
//   pulso_salida     one-cycle car-at-exit pulse
//   ocupados         occupied spaces (registered)
//   libres           CAPACIDAD - ocupados (registered)
//   lleno / vacio    full / empty flags (registered)
//   barrera_entrada  entry barrier open
//   barrera_salida   exit barrier open
//   rechazo          one-cycle pulse: event refused or dropped
//
// Build option: define ARBITRO_ROUND_ROBIN_EN to alternate the winner when
// entry and exit requests collide (exit wins first after reset). Without it,
// exit always has priority.
//
// state        | meaning
// REPOSO       | idle, barriers closed, evaluating requests
// ABRE_ENTRADA | entry barrier open, timer counting down
// ABRE_SALIDA  | exit barrier open, timer counting down

module control_estacionamiento #(
  parameter logic [7:0]  CAPACIDAD  = 8'd20,
  parameter logic [23:0] GATE_TICKS = 24'd6_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulso_entrada,
  input  logic       pulso_salida,
  output logic [7:0] ocupados,
  output logic [7:0] libres,
  output logic       lleno,
  output logic       vacio,
  output logic       barrera_entrada,
  output logic       barrera_salida,
  output logic       rechazo
);

  typedef enum logic [1:0] {
    REPOSO       = 2'd0,
    ABRE_ENTRADA = 2'd1,
    ABRE_SALIDA  = 2'd2
  } estado_t;

  estado_t     state, state_n;
  logic [23:0] timer, timer_n;
  logic [7:0]  ocup_n;
  logic        pend_in, pend_in_n;
  logic        pend_out, pend_out_n;
  logic        rech_n;
  logic        req_in, req_out;
  logic        serve_in, serve_out, ref_in, ref_out;

`ifdef ARBITRO_ROUND_ROBIN_EN
  // Set when the most recent grant went to the exit side.
  logic last_out, last_out_n;
`endif

  assign req_in  = pulso_entrada | pend_in;
  assign req_out = pulso_salida  | pend_out;

  // Grant / refusal decisions, only meaningful in REPOSO.
  always_comb begin
    serve_in  = 1'b0;
    serve_out = 1'b0;
    ref_in    = 1'b0;
    ref_out   = 1'b0;
    if (state == REPOSO) begin
      ref_out = req_out && (ocupados == 8'd0);
`ifdef ARBITRO_ROUND_ROBIN_EN
      // Entry wins a real collision only when exit took the last grant.
      serve_in  = req_in && (ocupados != CAPACIDAD) &&
                  (!(req_out && (ocupados != 8'd0)) || last_out);
      serve_out = req_out && (ocupados != 8'd0) && !serve_in;
`else
      serve_out = req_out && (ocupados != 8'd0);
      serve_in  = !serve_out && req_in && (ocupados != CAPACIDAD);
`endif
      // A full-side refusal applies only when the exit did not take the slot;
      // otherwise the entry request simply stays pending.
      ref_in = req_in && (ocupados == CAPACIDAD) && !serve_out;
    end
  end

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    ocup_n     = ocupados;
    rech_n     = 1'b0;
`ifdef ARBITRO_ROUND_ROBIN_EN
    last_out_n = last_out;
`endif

    unique case (state)
      REPOSO: begin
        if (serve_out) begin
          ocup_n  = ocupados - 8'd1;
          timer_n = GATE_TICKS - 24'd1;
          state_n = ABRE_SALIDA;
`ifdef ARBITRO_ROUND_ROBIN_EN
          last_out_n = 1'b1;
`endif
        end else if (serve_in) begin
          ocup_n  = ocupados + 8'd1;
          timer_n = GATE_TICKS - 24'd1;
          state_n = ABRE_ENTRADA;
`ifdef ARBITRO_ROUND_ROBIN_EN
          last_out_n = 1'b0;
`endif
        end
      end
      ABRE_ENTRADA, ABRE_SALIDA: begin
        if (timer == 24'd0) state_n = REPOSO;
        else                timer_n = timer - 24'd1;
      end
      default: state_n = REPOSO;
    endcase

    // Pending flags are one deep: a pulse on top of a set flag is lost.
    pend_in_n  = (serve_in  || ref_in)  ? 1'b0 : (pulso_entrada ? 1'b1 : pend_in);
    pend_out_n = (serve_out || ref_out) ? 1'b0 : (pulso_salida  ? 1'b1 : pend_out);

    if (ref_in || ref_out || (pulso_entrada && pend_in) || (pulso_salida && pend_out))
      rech_n = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= REPOSO;
      timer    <= 24'd0;
      ocupados <= 8'd0;
      libres   <= CAPACIDAD;
      lleno    <= 1'b0;
      vacio    <= 1'b1;
      pend_in  <= 1'b0;
      pend_out <= 1'b0;
      rechazo  <= 1'b0;
`ifdef ARBITRO_ROUND_ROBIN_EN
      last_out <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      ocupados <= ocup_n;
      libres   <= CAPACIDAD - ocup_n;
      lleno    <= (ocup_n == CAPACIDAD);
      vacio    <= (ocup_n == 8'd0);
      pend_in  <= pend_in_n;
      pend_out <= pend_out_n;
      rechazo  <= rech_n;
`ifdef ARBITRO_ROUND_ROBIN_EN
      last_out <= last_out_n;
`endif
    end
  end

  // Decoded straight from the state register so reset closes them at once.
  assign barrera_entrada = (state == ABRE_ENTRADA);
  assign barrera_salida  = (state == ABRE_SALIDA);

endmodule

// File: tb/tb_control_estacionamiento.sv
// Directed bench for control_estacionamiento with CAPACIDAD=3, GATE_TICKS=4.
module tb_control_estacionamiento;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulso_entrada = 1'b0;
  logic       pulso_salida = 1'b0;
  logic [7:0] ocupados, libres;
  logic       lleno, vacio, barrera_entrada, barrera_salida, rechazo;

  int n_cmp = 0;
  int n_err = 0;

  control_estacionamiento #(.CAPACIDAD(8'd3), .GATE_TICKS(24'd4)) dut (
    .clk(clk), .rst(rst),
    .pulso_entrada(pulso_entrada), .pulso_salida(pulso_salida),
    .ocupados(ocupados), .libres(libres), .lleno(lleno), .vacio(vacio),
    .barrera_entrada(barrera_entrada), .barrera_salida(barrera_salida),
    .rechazo(rechazo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count cycles with the chosen barrier high over a fixed window,
  // starting with the current cycle.
  task automatic count_barrier(input bit entrada, input int win, output int n);
    n = 0;
    for (int i = 0; i < win; i++) begin
      if (entrada ? barrera_entrada : barrera_salida) n++;
      tick();
    end
  endtask

  task automatic salida_once(input logic [7:0] exp_ocup);
    int n;
    pulso_salida = 1'b1; tick(); pulso_salida = 1'b0;
    chk("salida_ocup", ocupados, exp_ocup);
    count_barrier(1'b0, 9, n);
    chk("salida_len", n, 4);
  endtask

  initial begin
    int n;
    int n_any;
    bit first_in;

    // 1. reset and idle
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_ocup", ocupados, 0);
    chk("rst_libres", libres, 3);
    chk("rst_vacio", vacio, 1);
    chk("rst_lleno", lleno, 0);
    chk("rst_bar_in", barrera_entrada, 0);
    chk("rst_bar_out", barrera_salida, 0);
    chk("rst_rechazo", rechazo, 0);

    // 4. exit while empty
    pulso_salida = 1'b1; tick(); pulso_salida = 1'b0;
    chk("vacio_rechazo", rechazo, 1);
    chk("vacio_ocup", ocupados, 0);
    chk("vacio_bar", barrera_salida, 0);
    tick();
    chk("vacio_rechazo_1c", rechazo, 0);
    chk("vacio_bar2", barrera_salida, 0);

    // 2. fill up
    for (int k = 1; k <= 3; k++) begin
      pulso_entrada = 1'b1; tick(); pulso_entrada = 1'b0;
      chk("fill_ocup", ocupados, k);
      chk("fill_libres", libres, 3 - k);
      chk("fill_vacio", vacio, 0);
      count_barrier(1'b1, 10, n);
      chk("fill_bar_len", n, 4);
    end
    chk("fill_lleno", lleno, 1);
    pulso_entrada = 1'b1; tick(); pulso_entrada = 1'b0;
    chk("full_rechazo", rechazo, 1);
    chk("full_ocup", ocupados, 3);
    chk("full_bar", barrera_entrada, 0);
    tick();
    chk("full_rechazo_1c", rechazo, 0);

    salida_once(8'd2);
    chk("post_exit_lleno", lleno, 0);

    // 3. collision at ocupados=2
`ifdef ARBITRO_ROUND_ROBIN_EN
    first_in = 1'b1;
`else
    first_in = 1'b0;
`endif
    pulso_entrada = 1'b1; pulso_salida = 1'b1; tick();
    pulso_entrada = 1'b0; pulso_salida = 1'b0;
    chk("col_ocup1", ocupados, first_in ? 3 : 1);
    for (int i = 0; i < 4; i++) begin
      chk("col_first_bar", first_in ? barrera_entrada : barrera_salida, 1);
      chk("col_other_bar", first_in ? barrera_salida : barrera_entrada, 0);
      tick();
    end
    chk("col_gap_in", barrera_entrada, 0);
    chk("col_gap_out", barrera_salida, 0);
    tick();
    chk("col_ocup2", ocupados, 2);
    count_barrier(!first_in, 9, n);
    chk("col_second_len", n, 4);

    salida_once(8'd1);
    salida_once(8'd0);

    // 5. two entry pulses during an open entry barrier
    pulso_entrada = 1'b1; tick(); pulso_entrada = 1'b0;
    chk("dbl_ocup1", ocupados, 1);
    tick();
    pulso_entrada = 1'b1; tick(); pulso_entrada = 1'b0;
    chk("dbl_no_rech", rechazo, 0);
    pulso_entrada = 1'b1; tick(); pulso_entrada = 1'b0;
    chk("dbl_rechazo", rechazo, 1);
    chk("dbl_ocup_hold", ocupados, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("dbl_ocup2", ocupados, 2);
    chk("dbl_bar_closed", barrera_entrada, 0);

    // 6. reset in the middle of an exit
    pulso_salida = 1'b1; tick(); pulso_salida = 1'b0;
    chk("mid_ocup", ocupados, 1);
    pulso_entrada = 1'b1; tick(); pulso_entrada = 1'b0;
    chk("mid_bar", barrera_salida, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_bar", barrera_salida, 0);
    chk("mid_rst_ocup", ocupados, 0);
    chk("mid_rst_libres", libres, 3);
    chk("mid_rst_vacio", vacio, 1);
    tick();
    rst = 1'b0;
    n_any = 0;
    for (int i = 0; i < 15; i++) begin
      if (barrera_entrada || barrera_salida) n_any++;
      tick();
    end
    chk("post_rst_no_bar", n_any, 0);
    chk("post_rst_ocup", ocupados, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
